// File: rtl/phase_timer_pkg.sv
// Shared types and elaboration helpers for the phase timer.
// Define PHASE_TIMER_SHORT_TICK_EN to force the prescaler divide to 4 for fast simulation.
package phase_timer_pkg;

  localparam int unsigned CLK_HZ_DEF = 50000000;
  localparam int unsigned NUM_CH_DEF = 4;

  typedef enum logic {
    StIdle,
    StRun
  } ch_state_e;

  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
`ifdef PHASE_TIMER_SHORT_TICK_EN
    calc_div = (clk_hz >= tick_hz) ? 4 : 4;
`else
    calc_div = clk_hz / tick_hz;
`endif
  endfunction

  // Prescaler count width; never narrower than one bit.
  function automatic int unsigned div_width(input int unsigned div);
    div_width = (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running shared prescaler: one registered tick pulse every DIV enabled cycles.
module tick_prescaler
  import phase_timer_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic tick_en,
  output logic tick
);

  if (DIV < 2) begin : g_div_check
    $error("tick_prescaler: DIV must be >= 2");
  end

  localparam int unsigned CW = div_width(DIV);
  localparam logic [CW-1:0] LastCnt = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (tick_en) begin
      if (cnt_q == LastCnt) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/phase_timer.sv
// Multi-channel loadable interval timer driven by one shared tick prescaler.
// Define PHASE_TIMER_SHORT_TICK_EN to force the prescaler divide to 4.
module phase_timer
  import phase_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = CLK_HZ_DEF,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned NUM_CH  = NUM_CH_DEF,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic                    tick_en,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       abort,
  input  logic [NUM_CH*CNT_W-1:0] load_val,
  output logic                    tick,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH*CNT_W-1:0] remaining
);

  localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);

  logic dec;

  tick_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .tick_en (tick_en),
    .tick    (tick)
  );

  // A tick already in flight when tick_en drops must not move any channel.
  assign dec = tick & tick_en;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] ld;

    assign ld = load_val[i*CNT_W +: CNT_W];

    // Priority: abort > start (load or zero-length) > tick decrement.
    always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      if (abort[i]) begin
        state_d = StIdle;
        rem_d   = '0;
      end else if (start[i]) begin
        if (ld != '0) begin
          state_d = StRun;
          rem_d   = ld;
        end else begin
          state_d = StIdle;
          rem_d   = '0;
          done_d  = 1'b1;
        end
      end else begin
        unique case (state_q)
          StRun: begin
            if (dec) begin
              if (rem_q <= CNT_W'(1)) begin
                state_d = StIdle;
                rem_d   = '0;
                done_d  = 1'b1;
              end else begin
                rem_d = rem_q - CNT_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
        state_q <= StIdle;
        rem_q   <= '0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        rem_q   <= rem_d;
        done_q  <= done_d;
      end
    end

    assign busy[i]                      = (state_q == StRun);
    assign done[i]                      = done_q;
    assign remaining[i*CNT_W +: CNT_W]  = rem_q;
  end

endmodule

// File: tb/tb_phase_timer.sv
// Directed self-checking bench for phase_timer with a divide-by-4 prescaler.
module tb_phase_timer;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 8;

  logic            clk;
  logic            resetn;
  logic            tick_en;
  logic [NCH-1:0]  start;
  logic [NCH-1:0]  abort;
  logic [NCH*CW-1:0] load_val;
  logic            tick;
  logic [NCH-1:0]  busy;
  logic [NCH-1:0]  done;
  logic [NCH*CW-1:0] remaining;

  int n_cmp = 0;
  int n_err = 0;
  int en_cnt = 0;
  logic exp_tick = 1'b0;
  logic flag;

  phase_timer #(
    .CLK_HZ (4),
    .TICK_HZ(1),
    .NUM_CH (NCH),
    .CNT_W  (CW)
  ) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .tick_en  (tick_en),
    .start    (start),
    .abort    (abort),
    .load_val (load_val),
    .tick     (tick),
    .busy     (busy),
    .done     (done),
    .remaining(remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One clock edge; the tick model tracks enabled edges since the last reset.
  task automatic step();
    @(posedge clk);
    if (!resetn) begin
      en_cnt   = 0;
      exp_tick = 1'b0;
    end else if (tick_en) begin
      en_cnt++;
      exp_tick = (en_cnt % 4 == 0);
    end else begin
      exp_tick = 1'b0;
    end
    #1;
  endtask

  // Advance until the model says tick is high, confirm it, then take the decrement edge.
  task automatic tick_then_step(input string tag);
    int n = 0;
    while (!exp_tick && n < 8) begin
      step();
      n++;
    end
    check_eq({tag, "_tick"}, {31'd0, tick}, {31'd0, exp_tick});
    step();
  endtask

  function automatic logic [31:0] rem(input int ch);
    return {24'd0, remaining[ch*CW +: CW]};
  endfunction

  initial begin
    resetn   = 1'b0;
    tick_en  = 1'b0;
    start    = '0;
    abort    = '0;
    load_val = '0;
    repeat (3) step();
    check_eq("rst_tick", {31'd0, tick}, 32'd0);
    check_eq("rst_busy", {28'd0, busy}, 32'd0);
    check_eq("rst_done", {28'd0, done}, 32'd0);
    check_eq("rst_rem", remaining, 32'd0);

    resetn  = 1'b1;
    tick_en = 1'b1;
    flag = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      check_eq("tick_period", {31'd0, tick}, {31'd0, exp_tick});
      if (busy != '0 || done != '0 || remaining != '0) flag = 1'b1;
    end
    check_eq("idle_outputs", {31'd0, flag}, 32'd0);

    // ch0 counts 3 ticks
    start[0] = 1'b1;
    load_val[0 +: CW] = 8'd3;
    step();
    start[0] = 1'b0;
    check_eq("ch0_busy", {31'd0, busy[0]}, 32'd1);
    check_eq("ch0_rem3", rem(0), 32'd3);
    tick_then_step("ch0_a");
    check_eq("ch0_rem2", rem(0), 32'd2);
    check_eq("ch0_nodone", {31'd0, done[0]}, 32'd0);
    tick_then_step("ch0_b");
    check_eq("ch0_rem1", rem(0), 32'd1);
    tick_then_step("ch0_c");
    check_eq("ch0_rem0", rem(0), 32'd0);
    check_eq("ch0_done", {31'd0, done[0]}, 32'd1);
    check_eq("ch0_busy_off", {31'd0, busy[0]}, 32'd0);
    step();
    check_eq("ch0_done_pulse", {31'd0, done[0]}, 32'd0);

    // ch1 zero-length start
    start[1] = 1'b1;
    load_val[CW +: CW] = 8'd0;
    step();
    start[1] = 1'b0;
    check_eq("ch1_done", {31'd0, done[1]}, 32'd1);
    check_eq("ch1_busy", {31'd0, busy[1]}, 32'd0);
    step();
    check_eq("ch1_done_pulse", {31'd0, done[1]}, 32'd0);
    check_eq("ch1_busy2", {31'd0, busy[1]}, 32'd0);

    // ch2 retrigger coinciding with a tick
    start[2] = 1'b1;
    load_val[2*CW +: CW] = 8'd5;
    step();
    start[2] = 1'b0;
    check_eq("ch2_rem5", rem(2), 32'd5);
    tick_then_step("ch2_a");
    tick_then_step("ch2_b");
    check_eq("ch2_rem3", rem(2), 32'd3);
    for (int n = 0; n < 8 && !exp_tick; n++) step();
    check_eq("ch2_retrig_tick", {31'd0, tick}, 32'd1);
    start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    check_eq("ch2_reload", rem(2), 32'd5);
    for (int k = 4; k >= 1; k--) begin
      tick_then_step("ch2_run");
      check_eq("ch2_count", rem(2), k);
      check_eq("ch2_early_done", {31'd0, done[2]}, 32'd0);
    end
    tick_then_step("ch2_last");
    check_eq("ch2_done", {31'd0, done[2]}, 32'd1);
    check_eq("ch2_busy_off", {31'd0, busy[2]}, 32'd0);

    // ch3 abort beats start
    start[3] = 1'b1;
    load_val[3*CW +: CW] = 8'd4;
    step();
    check_eq("ch3_rem4", rem(3), 32'd4);
    load_val[3*CW +: CW] = 8'd9;
    abort[3] = 1'b1;
    step();
    start[3] = 1'b0;
    abort[3] = 1'b0;
    check_eq("ch3_abort_busy", {31'd0, busy[3]}, 32'd0);
    check_eq("ch3_abort_rem", rem(3), 32'd0);
    flag = done[3];
    for (int k = 0; k < 12; k++) begin
      step();
      if (done[3]) flag = 1'b1;
    end
    check_eq("ch3_no_done", {31'd0, flag}, 32'd0);

    // ch0 frozen by tick_en=0
    start[0] = 1'b1;
    load_val[0 +: CW] = 8'd2;
    step();
    start[0] = 1'b0;
    check_eq("ch0p_rem2", rem(0), 32'd2);
    tick_en = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (tick || rem(0) != 32'd2 || done[0]) flag = 1'b1;
    end
    check_eq("pause_frozen", {31'd0, flag}, 32'd0);
    tick_en = 1'b1;
    tick_then_step("ch0p_a");
    check_eq("ch0p_rem1", rem(0), 32'd1);
    tick_then_step("ch0p_b");
    check_eq("ch0p_done", {31'd0, done[0]}, 32'd1);

    // reset mid-run
    start[2] = 1'b1;
    load_val[2*CW +: CW] = 8'd7;
    step();
    start[2] = 1'b0;
    tick_then_step("rstrun");
    check_eq("rstrun_rem6", rem(2), 32'd6);
    resetn = 1'b0;
    step();
    check_eq("rstrun_busy", {28'd0, busy}, 32'd0);
    check_eq("rstrun_rem", remaining, 32'd0);
    check_eq("rstrun_done", {28'd0, done}, 32'd0);
    check_eq("rstrun_tick", {31'd0, tick}, 32'd0);
    resetn = 1'b1;
    flag = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (done != '0 || busy != '0) flag = 1'b1;
    end
    check_eq("rstrun_silent", {31'd0, flag}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
